reset_sequencer: RTL and testbench

Synthesizable global-reset sequencer for the SPEC FMC-ADC gateware that produces, in hardware, the staged release the simulation-only global model provides: a global set/reset, a global tri-state, and a preload strobe. It waits for the system PLL to lock, then releases the tri-state after a short interval and the global reset after a longer one. It sits between the clock/PLL block and every downstream reset consumer: ADC core, DDR controller, and GN4124 bridge logic.

---
 rtl/reset_seq_pkg.sv | 15 +
 rtl/reset_seq_sync.sv | 70 +++++++
 rtl/reset_sequencer.sv | 133 +++++++++++++
 tb/tb_reset_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the global-reset sequencer.
// The lock filter is enabled by defining RESET_SEQ_LOCK_FILTER_EN.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        COUNT     = 2'd2,
        RUN       = 2'd3
    } reset_seq_state_t;

    localparam int RESET_SEQ_SYNC_STAGES = 2;
    localparam int RESET_SEQ_FILT_LEN    = 8;

endpackage

// File: rtl/reset_seq_sync.sv
// PLL lock synchronizer with an optional rise filter.
// Define RESET_SEQ_LOCK_FILTER_EN to require 8 stable cycles before lock_s_o rises.
module reset_seq_sync
    import reset_seq_pkg::*;
(
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic pll_locked_i,
    output logic lock_s_o
);

    logic [RESET_SEQ_SYNC_STAGES-1:0] sync_q;
    logic [RESET_SEQ_SYNC_STAGES-1:0] sync_d;
    logic                             lock_sync;

    always_comb begin
        sync_d = {sync_q[RESET_SEQ_SYNC_STAGES-2:0], pll_locked_i};
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign lock_sync = sync_q[RESET_SEQ_SYNC_STAGES-1];

`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int FILT_W = $clog2(RESET_SEQ_FILT_LEN);

    logic [FILT_W-1:0] filt_cnt_q;
    logic [FILT_W-1:0] filt_cnt_d;
    logic              lock_filt_q;
    logic              lock_filt_d;

    // Any low sample restarts the stability count; the filtered lock latches once the count saturates.
    always_comb begin
        filt_cnt_d  = filt_cnt_q;
        lock_filt_d = lock_filt_q;
        if (!lock_sync) begin
            filt_cnt_d  = '0;
            lock_filt_d = 1'b0;
        end else if (!lock_filt_q) begin
            if (filt_cnt_q == FILT_W'(RESET_SEQ_FILT_LEN - 1)) begin
                lock_filt_d = 1'b1;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            filt_cnt_q  <= '0;
            lock_filt_q <= 1'b0;
        end else begin
            filt_cnt_q  <= filt_cnt_d;
            lock_filt_q <= lock_filt_d;
        end
    end

    // Gating with the raw synchronized level makes the fall immediate.
    assign lock_s_o = lock_sync & lock_filt_q;
`else
    assign lock_s_o = lock_sync;
`endif

endmodule

// File: rtl/reset_sequencer.sv
// Staged global-reset release (GSR/GTS/PRLD) after PLL lock.
// Optional lock filter: define RESET_SEQ_LOCK_FILTER_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int ROC_CYCLES = 1000,
    parameter int TOC_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       pll_locked_i,
    input  logic       soft_rst_i,
    output logic       gsr_o,
    output logic       gts_o,
    output logic       prld_o,
    output logic       rst_done_o,
    output logic [1:0] state_o
);

    if (ROC_CYCLES < 1) begin : g_bad_roc
        $error("reset_sequencer: ROC_CYCLES must be >= 1");
    end
    if (longint'(ROC_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("reset_sequencer: ROC_CYCLES does not fit in CNT_W bits");
    end

    localparam int               TOC_EFF = (TOC_CYCLES >= ROC_CYCLES) ? ROC_CYCLES : TOC_CYCLES;
    localparam logic [CNT_W-1:0] ROC_VAL = CNT_W'(ROC_CYCLES);
    localparam logic [CNT_W-1:0] TOC_VAL = CNT_W'(TOC_EFF);

    logic             lock_s;
    reset_seq_state_t state_q;
    reset_seq_state_t state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             gsr_q;
    logic             gsr_d;
    logic             gts_q;
    logic             gts_d;
    logic             done_q;
    logic             done_d;
    logic             restart;

    reset_seq_sync u_sync (
        .sys_clk_i    (sys_clk_i),
        .sys_rst_i    (sys_rst_i),
        .pll_locked_i (pll_locked_i),
        .lock_s_o     (lock_s)
    );

    assign cnt_inc = cnt_q + 1'b1;
    assign restart = soft_rst_i | ~lock_s;

    // Outputs are computed alongside the next state so they toggle on the same edge as the transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gsr_d   = gsr_q;
        gts_d   = gts_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                state_d = WAIT_LOCK;
                gsr_d   = 1'b1;
                gts_d   = 1'b1;
                done_d  = 1'b0;
            end
            WAIT_LOCK: begin
                if (!soft_rst_i && lock_s) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                    if (TOC_VAL == '0) begin
                        gts_d = 1'b0;
                    end
                end
            end
            COUNT: begin
                if (restart) begin
                    state_d = WAIT_LOCK;
                    gsr_d   = 1'b1;
                    gts_d   = 1'b1;
                    done_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TOC_VAL) begin
                        gts_d = 1'b0;
                    end
                    if (cnt_inc == ROC_VAL) begin
                        state_d = RUN;
                        gsr_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (restart) begin
                    state_d = WAIT_LOCK;
                    gsr_d   = 1'b1;
                    gts_d   = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gsr_q   <= 1'b1;
            gts_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gsr_q   <= gsr_d;
            gts_q   <= gts_d;
            done_q  <= done_d;
        end
    end

    assign gsr_o      = gsr_q;
    assign prld_o     = gsr_q;
    assign gts_o      = gts_q;
    assign rst_done_o = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: main instance (ROC=20,TOC=4), clipped (TOC=50) and TOC=0 instances.
// Latencies grow by 8 edges when RESET_SEQ_LOCK_FILTER_EN is defined.
module tb_reset_sequencer;

`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int FILT_ADD = 8;
`else
    localparam int FILT_ADD = 0;
`endif
    localparam int ROC = 20;
    localparam int TOC = 4;
    localparam int L   = 3 + FILT_ADD;

    logic       sys_clk_i = 1'b0;
    logic       sys_rst_i = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       soft_rst_i = 1'b0;

    logic       gsr_a, gts_a, prld_a, done_a;
    logic [1:0] st_a;
    logic       gsr_c, gts_c, prld_c, done_c;
    logic [1:0] st_c;
    logic       gsr_z, gts_z, prld_z, done_z;
    logic [1:0] st_z;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk_i = ~sys_clk_i;

    reset_sequencer #(.ROC_CYCLES(ROC), .TOC_CYCLES(TOC), .CNT_W(16)) dut (
        .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .pll_locked_i(pll_locked_i),
        .soft_rst_i(soft_rst_i), .gsr_o(gsr_a), .gts_o(gts_a), .prld_o(prld_a),
        .rst_done_o(done_a), .state_o(st_a)
    );

    reset_sequencer #(.ROC_CYCLES(ROC), .TOC_CYCLES(50), .CNT_W(8)) dut_clip (
        .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .pll_locked_i(pll_locked_i),
        .soft_rst_i(soft_rst_i), .gsr_o(gsr_c), .gts_o(gts_c), .prld_o(prld_c),
        .rst_done_o(done_c), .state_o(st_c)
    );

    reset_sequencer #(.ROC_CYCLES(ROC), .TOC_CYCLES(0), .CNT_W(8)) dut_toc0 (
        .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .pll_locked_i(pll_locked_i),
        .soft_rst_i(soft_rst_i), .gsr_o(gsr_z), .gts_o(gts_z), .prld_o(prld_z),
        .rst_done_o(done_z), .state_o(st_z)
    );

    // Advance n active edges, then settle 1 time unit past the edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk_i);
        #1;
    endtask

    // Checks a full lock-to-RUN sequence; pll_locked_i has just been raised after the current edge.
    task automatic run_sequence(input string tag);
        logic [1:0] exp_st;
        for (int k = 1; k <= L + ROC + 2; k++) begin
            step(1);
            exp_st = (k < L) ? 2'd1 : ((k < L + ROC) ? 2'd2 : 2'd3);
            if (st_a !== exp_st) begin n_err++; $display("[TB] FAIL %s.state k=%0d got=%0d exp=%0d", tag, k, st_a, exp_st); end
            n_cmp++;
            if (gts_a !== (k < L + TOC)) begin n_err++; $display("[TB] FAIL %s.gts k=%0d got=%b exp=%b", tag, k, gts_a, (k < L + TOC)); end
            n_cmp++;
            if (gsr_a !== (k < L + ROC)) begin n_err++; $display("[TB] FAIL %s.gsr k=%0d got=%b exp=%b", tag, k, gsr_a, (k < L + ROC)); end
            n_cmp++;
            if (prld_a !== (k < L + ROC)) begin n_err++; $display("[TB] FAIL %s.prld k=%0d got=%b exp=%b", tag, k, prld_a, (k < L + ROC)); end
            n_cmp++;
            if (done_a !== (k >= L + ROC)) begin n_err++; $display("[TB] FAIL %s.done k=%0d got=%b exp=%b", tag, k, done_a, (k >= L + ROC)); end
            n_cmp++;
            if (gts_c !== (k < L + ROC)) begin n_err++; $display("[TB] FAIL %s.clip_gts k=%0d got=%b exp=%b", tag, k, gts_c, (k < L + ROC)); end
            n_cmp++;
            if (gsr_c !== (k < L + ROC)) begin n_err++; $display("[TB] FAIL %s.clip_gsr k=%0d got=%b exp=%b", tag, k, gsr_c, (k < L + ROC)); end
            n_cmp++;
            if (gts_z !== (k < L)) begin n_err++; $display("[TB] FAIL %s.toc0_gts k=%0d got=%b exp=%b", tag, k, gts_z, (k < L)); end
            n_cmp++;
        end
    endtask

    task automatic test_reset();
        sys_rst_i = 1'b1;
        pll_locked_i = 1'b0;
        soft_rst_i = 1'b0;
        step(3);
        if (st_a !== 2'd0) begin n_err++; $display("[TB] FAIL reset.state got=%0d exp=0", st_a); end
        n_cmp++;
        if ({gsr_a, gts_a, prld_a, done_a} !== 4'b1110) begin n_err++; $display("[TB] FAIL reset.outs got=%b exp=1110", {gsr_a, gts_a, prld_a, done_a}); end
        n_cmp++;
        sys_rst_i = 1'b0;
        step(1);
        if (st_a !== 2'd1) begin n_err++; $display("[TB] FAIL reset.idle_exit got=%0d exp=1", st_a); end
        n_cmp++;
        step(4);
        if (st_a !== 2'd1) begin n_err++; $display("[TB] FAIL reset.wait_lock got=%0d exp=1", st_a); end
        n_cmp++;
    endtask

`ifdef RESET_SEQ_LOCK_FILTER_EN
    task automatic test_filter_glitch();
        pll_locked_i = 1'b1;
        step(5);
        pll_locked_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (st_a !== 2'd1) begin n_err++; $display("[TB] FAIL filter.glitch k=%0d got=%0d exp=1", k, st_a); end
            n_cmp++;
        end
    endtask
`endif

    task automatic test_basic();
        pll_locked_i = 1'b1;
        run_sequence("basic");
    endtask

    task automatic test_lock_loss();
        logic [1:0] exp_st;
        // Lock fall while in RUN
        pll_locked_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            exp_st = (k < 3) ? 2'd3 : 2'd1;
            if (st_a !== exp_st) begin n_err++; $display("[TB] FAIL lossrun.state k=%0d got=%0d exp=%0d", k, st_a, exp_st); end
            n_cmp++;
        end
        if ({gsr_a, gts_a, prld_a, done_a} !== 4'b1110) begin n_err++; $display("[TB] FAIL lossrun.outs got=%b exp=1110", {gsr_a, gts_a, prld_a, done_a}); end
        n_cmp++;
        step(2);
        // Relock and drop while cnt == 10
        pll_locked_i = 1'b1;
        step(L + 10);
        if (st_a !== 2'd2 || gts_a !== 1'b0) begin n_err++; $display("[TB] FAIL losscnt.pre got=%0d/%b exp=2/0", st_a, gts_a); end
        n_cmp++;
        pll_locked_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            exp_st = (k < 3) ? 2'd2 : 2'd1;
            if (st_a !== exp_st) begin n_err++; $display("[TB] FAIL losscnt.state k=%0d got=%0d exp=%0d", k, st_a, exp_st); end
            n_cmp++;
            if (gts_a !== (k >= 3)) begin n_err++; $display("[TB] FAIL losscnt.gts k=%0d got=%b exp=%b", k, gts_a, (k >= 3)); end
            n_cmp++;
        end
        if ({gsr_a, prld_a, done_a} !== 3'b110) begin n_err++; $display("[TB] FAIL losscnt.outs got=%b exp=110", {gsr_a, prld_a, done_a}); end
        n_cmp++;
        pll_locked_i = 1'b1;
        run_sequence("relock");
    endtask

    task automatic test_soft_rst_run();
        logic [1:0] exp_st;
        soft_rst_i = 1'b1;
        step(1);
        soft_rst_i = 1'b0;
        if ({gsr_a, gts_a, prld_a, done_a} !== 4'b1110) begin n_err++; $display("[TB] FAIL soft.outs got=%b exp=1110", {gsr_a, gts_a, prld_a, done_a}); end
        n_cmp++;
        if (st_a !== 2'd1) begin n_err++; $display("[TB] FAIL soft.state got=%0d exp=1", st_a); end
        n_cmp++;
        for (int k = 2; k <= 23; k++) begin
            step(1);
            exp_st = (k < 2) ? 2'd1 : ((k < 22) ? 2'd2 : 2'd3);
            if (st_a !== exp_st) begin n_err++; $display("[TB] FAIL soft.seq_state k=%0d got=%0d exp=%0d", k, st_a, exp_st); end
            n_cmp++;
            if (gsr_a !== (k < 22)) begin n_err++; $display("[TB] FAIL soft.gsr k=%0d got=%b exp=%b", k, gsr_a, (k < 22)); end
            n_cmp++;
            if (gts_a !== (k < 6)) begin n_err++; $display("[TB] FAIL soft.gts k=%0d got=%b exp=%b", k, gts_a, (k < 6)); end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back();
        pll_locked_i = 1'b0;
        step(2);
        if (st_a !== 2'd3) begin n_err++; $display("[TB] FAIL b2b.pre got=%0d exp=3", st_a); end
        n_cmp++;
        soft_rst_i = 1'b1;
        step(1);
        soft_rst_i = 1'b0;
        if (st_a !== 2'd1 || gsr_a !== 1'b1 || done_a !== 1'b0) begin n_err++; $display("[TB] FAIL b2b.hit got=%0d/%b/%b exp=1/1/0", st_a, gsr_a, done_a); end
        n_cmp++;
        step(3);
        if (st_a !== 2'd1) begin n_err++; $display("[TB] FAIL b2b.hold got=%0d exp=1", st_a); end
        n_cmp++;
    endtask

    task automatic test_sys_rst_mid_count();
        pll_locked_i = 1'b1;
        step(L + 5);
        if (st_a !== 2'd2) begin n_err++; $display("[TB] FAIL sysrst.pre got=%0d exp=2", st_a); end
        n_cmp++;
        sys_rst_i = 1'b1;
        step(1);
        if (st_a !== 2'd0 || st_c !== 2'd0) begin n_err++; $display("[TB] FAIL sysrst.state got=%0d/%0d exp=0/0", st_a, st_c); end
        n_cmp++;
        if ({gsr_a, gts_a, prld_a, done_a} !== 4'b1110) begin n_err++; $display("[TB] FAIL sysrst.outs got=%b exp=1110", {gsr_a, gts_a, prld_a, done_a}); end
        n_cmp++;
        step(1);
        if (st_a !== 2'd0) begin n_err++; $display("[TB] FAIL sysrst.hold got=%0d exp=0", st_a); end
        n_cmp++;
        sys_rst_i = 1'b0;
        step(1);
        if (st_a !== 2'd1) begin n_err++; $display("[TB] FAIL sysrst.release got=%0d exp=1", st_a); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
`ifdef RESET_SEQ_LOCK_FILTER_EN
        test_filter_glitch();
`endif
        test_basic();
        test_lock_loss();
        test_soft_rst_run();
        test_back_to_back();
        test_sys_rst_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
